// File: rtl/encoder_pkg.sv
// Shared constants for the request encoder: priority modes and FSM encodings.
// Latency: none (declarations only).
// Backpressure: not applicable.
package encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_search.sv
// Combinational fixed/round-robin search over a request vector.
// Latency: zero cycles.
// Backpressure: none; the caller decides when to register the result.
module rr_priority_search
  import encoder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [OUT_WIDTH-1:0] ptr,
  input  logic                 mode,
  output logic [OUT_WIDTH-1:0] index,
  output logic                 found,
  output logic                 multi
);

  localparam int DW = 2 * WIDTH;

  logic [OUT_WIDTH-1:0] eff_ptr;
  logic [DW-1:0]        window;
  logic [DW-1:0]        masked;

  // Doubling the vector turns the wrap-around into a plain lowest-bit search
  // over a WIDTH-bit window starting at the pointer.
  always_comb begin
    eff_ptr = (mode == 1'(MODE_RR)) ? ptr : '0;
    window  = {{WIDTH{1'b0}}, {WIDTH{1'b1}}} << eff_ptr;
    masked  = {req, req} & window;
    index   = '0;
    found   = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) begin
        index = OUT_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

  assign multi = |(req & (req - WIDTH'(1)));

endmodule

// File: rtl/rr_encoder.sv
// Registered N-to-log2(N) request encoder, fixed or round-robin; ENCODER_LATCH_EN adds sticky requests.
// Latency: one cycle from request to O_VALID; back-to-back one index per cycle.
// Backpressure: held index frozen while O_VALID && !I_READY; a grant is never withdrawn.
module rr_encoder
  import encoder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_FIXED
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_ENABLE,
  input  logic [WIDTH-1:0]           I_DATA,
  input  logic                       I_READY,
  output logic                       O_VALID,
  output logic [$clog2(WIDTH)-1:0]   O_DATA,
  output logic                       O_MULTI
);

  localparam int   OUT_WIDTH = $clog2(WIDTH);
  localparam logic RR_MODE   = (MODE == MODE_RR);

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] ptr_q, ptr_d, ptr_inc, search_ptr;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 multi_q, multi_d;
  logic                 accept;
  logic [WIDTH-1:0]     req;
  logic [OUT_WIDTH-1:0] sel_index;
  logic                 sel_found, sel_multi;

  assign accept     = (state_q == HOLD) && I_READY;
  assign ptr_inc    = data_q + OUT_WIDTH'(1);
  assign search_ptr = (RR_MODE && accept) ? ptr_inc : ptr_q;

`ifdef ENCODER_LATCH_EN
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_kept;

  // The accepted bit is dropped before new requests are OR-ed back in, so a
  // pulse landing in the acceptance cycle survives.
  assign pending_kept = accept ? (pending_q & ~(WIDTH'(1) << data_q)) : pending_q;
  assign req          = I_DATA | pending_kept;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) pending_q <= '0;
    else           pending_q <= pending_kept | I_DATA;
  end
`else
  assign req = I_DATA;
`endif

  rr_priority_search #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_search (
    .req   (req),
    .ptr   (search_ptr),
    .mode  (RR_MODE),
    .index (sel_index),
    .found (sel_found),
    .multi (sel_multi)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    multi_d = multi_q;
    case (state_q)
      IDLE: begin
        if (I_ENABLE && sel_found) begin
          state_d = HOLD;
          data_d  = sel_index;
          multi_d = sel_multi;
        end
      end
      HOLD: begin
        if (I_READY) begin
          if (RR_MODE) ptr_d = ptr_inc;
          if (I_ENABLE && sel_found) begin
            data_d  = sel_index;
            multi_d = sel_multi;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      multi_q <= multi_d;
    end
  end

  assign O_VALID = (state_q == HOLD);
  assign O_DATA  = data_q;
  assign O_MULTI = multi_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Scoreboard bench for rr_encoder: one fixed-priority and one round-robin instance.
module tb_rr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, rdy0 = 1'b0, vld0, multi0;
  logic [15:0] dat0 = '0;
  logic [3:0]  o_dat0;
  logic        en1 = 1'b0, rdy1 = 1'b0, vld1, multi1;
  logic [15:0] dat1 = '0;
  logic [3:0]  o_dat1;

  int checks = 0;
  int errors = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  rr_encoder #(.WIDTH(16), .MODE(0)) u_fixed (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en0), .I_DATA(dat0), .I_READY(rdy0),
    .O_VALID(vld0), .O_DATA(o_dat0), .O_MULTI(multi0)
  );

  rr_encoder #(.WIDTH(16), .MODE(1)) u_rr (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en1), .I_DATA(dat1), .I_READY(rdy1),
    .O_VALID(vld1), .O_DATA(o_dat1), .O_MULTI(multi1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ex(input int idx, input bit m);
    return {4'(idx), m};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every transfer (valid && ready ahead of a rising edge) pops one expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && vld0 && rdy0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL fixed_unexpected actual=%0d expected=none", o_dat0);
      end else begin
        e = q0.pop_front();
        chk("fixed_idx", 32'(o_dat0), 32'(e[4:1]));
        chk("fixed_multi", 32'(multi0), 32'(e[0]));
      end
    end
    if (rst_n && vld1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected actual=%0d expected=none", o_dat1);
      end else begin
        e = q1.pop_front();
        chk("rr_idx", 32'(o_dat1), 32'(e[4:1]));
        chk("rr_multi", 32'(multi1), 32'(e[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_fixed_vld", 32'(vld0), 0);
    chk("rst_fixed_idx", 32'(o_dat0), 0);
    chk("rst_fixed_multi", 32'(multi0), 0);
    chk("rst_rr_vld", 32'(vld1), 0);
    chk("rst_rr_idx", 32'(o_dat1), 0);
    chk("rst_rr_multi", 32'(multi1), 0);
    step; step;
    rst_n = 1'b1;

    // Reset asserted mid-HOLD clears outputs without a clock edge
    en1 = 1'b1; dat1 = 16'h0200;
    step;
    chk("rr_hold_vld", 32'(vld1), 1);
    chk("rr_hold_idx", 32'(o_dat1), 9);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(vld1), 0);
    chk("async_rst_idx", 32'(o_dat1), 0);
    chk("async_rst_multi", 32'(multi1), 0);
    #2 rst_n = 1'b1;

    // Round-robin fairness from a pointer of zero, no bubbles
    dat1 = 16'h8001; en1 = 1'b1; rdy1 = 1'b1;
    q1.push_back(ex(0, 1)); q1.push_back(ex(15, 1));
    q1.push_back(ex(0, 1)); q1.push_back(ex(15, 1));
    for (int k = 0; k < 4; k++) begin
      step;
      chk("rr_no_bubble", 32'(vld1), 1);
    end
    // Pointer wraps to 0 after accepting 15
    dat1 = 16'h4002;
`ifdef ENCODER_LATCH_EN
    q1.push_back(ex(0, 1));
`else
    q1.push_back(ex(1, 1));
`endif
    step;
    en1 = 1'b0;
    step;
    rdy1 = 1'b0;
    chk("rr_idle_after", 32'(vld1), 0);

    // Fixed priority: hold stability under backpressure
    dat0 = 16'h0120; en0 = 1'b1;
    step;
    dat0 = 16'h8000;
    for (int k = 0; k < 3; k++) begin
      chk("fixed_hold_vld", 32'(vld0), 1);
      chk("fixed_hold_idx", 32'(o_dat0), 5);
      chk("fixed_hold_multi", 32'(multi0), 1);
      step;
    end
    rdy0 = 1'b1;
    q0.push_back(ex(5, 1));
`ifdef ENCODER_LATCH_EN
    q0.push_back(ex(8, 1));
`else
    q0.push_back(ex(15, 0));
`endif
    step;
    chk("fixed_b2b_vld", 32'(vld0), 1);
    en0 = 1'b0;
    step;
    rdy0 = 1'b0;
    chk("fixed_idle_after", 32'(vld0), 0);
    pulse_reset;

    // Enable gating
    dat0 = 16'h0010; en0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("gated_vld", 32'(vld0), 0);
    end
    en0 = 1'b1;
    q0.push_back(ex(4, 0));
    step;
    chk("gate_open_vld", 32'(vld0), 1);
    en0 = 1'b0; rdy0 = 1'b1;
    step;
    rdy0 = 1'b0;
    chk("gate_idle_after", 32'(vld0), 0);
    pulse_reset;

    // Single-cycle pulse while holding
    dat0 = 16'h0002; en0 = 1'b1;
    step;
    dat0 = 16'h0400;
    step;
    dat0 = 16'h0000; rdy0 = 1'b1;
    q0.push_back(ex(1, 0));
`ifdef ENCODER_LATCH_EN
    q0.push_back(ex(10, 0));
`endif
    step;
`ifdef ENCODER_LATCH_EN
    chk("pulse_kept_vld", 32'(vld0), 1);
`else
    chk("pulse_dropped_vld", 32'(vld0), 0);
`endif
    en0 = 1'b0;
    step;
    rdy0 = 1'b0;
    chk("pulse_final_vld", 32'(vld0), 0);

    step;
    chk("fixed_queue_empty", 32'(q0.size()), 0);
    chk("rr_queue_empty", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
